// File: rtl/pio_poll_pkg.sv
// Shared types and sizing for the PIO change poller.
// Holds the FSM state enum, the event record and the FIFO pointer width.
package pio_poll_pkg;

    localparam int DATA_W = 5;
    localparam int TS_W   = 16;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        CAPTURE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] rise;
        logic [DATA_W-1:0] fall;
        logic [TS_W-1:0]   ts;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

endpackage

// File: rtl/pio_evt_fifo.sv
// First-word-fall-through event FIFO with drop-on-full and sticky overflow.
// Ports: clk, reset, push/din (write), ready (pop when valid), dout/valid
// (head entry), clr_ovf (clear overflow), overflow (an entry was dropped).
module pio_evt_fifo
    import pio_poll_pkg::*;
#(
    parameter int WIDTH = EVT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             clr_ovf,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wptr;
    logic [PTR_W:0]   rptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    // Extra MSB on the pointers tells full from empty.
    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                   (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);

    assign do_pop  = ready & ~empty;
    // A full FIFO still takes the push if the head leaves this cycle.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign valid = ~empty;
    assign dout  = mem[rptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[PTR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (PTR_W+1)'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set.
            overflow <= drop | (overflow & ~clr_ovf);
        end
    end

endmodule

// File: rtl/pio_change_poller.sv
// Avalon-MM read initiator that polls a PIO and streams per-bit change events.
// Ports: clk, reset, enable, clr_ovf; avm_address/avm_read/avm_readdata
// (master side); evt_valid/evt_ready/evt_value/evt_rise/evt_fall/evt_ts
// (event stream); overflow (events dropped); primed (baseline exists).
module pio_change_poller
    import pio_poll_pkg::*;
#(
    parameter int         POLL_DIV     = 1024,
    parameter int         READ_LATENCY = 1,
    parameter logic [1:0] POLL_ADDR    = 2'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clr_ovf,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_value,
    output logic [DATA_W-1:0] evt_rise,
    output logic [DATA_W-1:0] evt_fall,
    output logic [TS_W-1:0]   evt_ts,
    output logic              overflow,
    output logic              primed
);

    localparam int TMR_W = $clog2(POLL_DIV);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_DIV - 1);
    localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

    state_t            state;
    state_t            state_nx;
    logic [TMR_W-1:0]  tmr;
    logic [TS_W-1:0]   ts;
    logic [1:0]        wcnt;
    logic [DATA_W-1:0] samp;
    logic [DATA_W-1:0] baseline;
    logic              push;
    evt_t              evt_in;
    evt_t              head;
    logic              tmr_zero;
    logic              unused_hi;

    assign unused_hi   = ^avm_readdata[31:DATA_W];
    assign avm_address = POLL_ADDR;
    assign tmr_zero    = (tmr == '0);

    always_comb begin
        state_nx = state;
        avm_read = 1'b0;
        unique case (state)
            IDLE: begin
                // Expiry outside IDLE is simply lost, never queued.
                if (tmr_zero && enable) begin
                    state_nx = READ;
                end
            end
            READ: begin
                avm_read = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (wcnt == 2'd0) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tmr      <= TMR_RELOAD;
            ts       <= '0;
            wcnt     <= '0;
            samp     <= '0;
            baseline <= '0;
            primed   <= 1'b0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_zero ? TMR_RELOAD : tmr - TMR_W'(1);
            ts    <= ts + TS_W'(1);
            if (state == READ) begin
                wcnt <= WAIT_LOAD;
            end else if (state == WAIT) begin
                wcnt <= wcnt - 2'd1;
            end
            // Latch readdata in the cycle it is valid; CAPTURE uses the copy.
            if (state == WAIT && wcnt == 2'd0) begin
                samp <= avm_readdata[DATA_W-1:0];
            end
            // Baseline follows every sample, even when the event is dropped.
            if (state == CAPTURE) begin
                primed   <= 1'b1;
                baseline <= samp;
            end
        end
    end

    assign push = (state == CAPTURE) && primed && (samp != baseline);

    always_comb begin
        evt_in       = '0;
        evt_in.value = samp;
        evt_in.rise  = samp & ~baseline;
        evt_in.fall  = ~samp & baseline;
        evt_in.ts    = ts;
    end

    pio_evt_fifo #(
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (evt_in),
        .ready    (evt_ready),
        .dout     (head),
        .valid    (evt_valid),
        .clr_ovf  (clr_ovf),
        .overflow (overflow)
    );

    assign evt_value = head.value;
    assign evt_rise  = head.rise;
    assign evt_fall  = head.fall;
    assign evt_ts    = head.ts;

endmodule

// File: doc/pio_change_poller.md
Name: pio_change_poller

Overview:
- Avalon-MM read initiator that periodically polls a 32-bit read-only PIO slave (for example, the 5-bit FPGA status input port).
- Detects per-bit changes between successive samples and queues change events in a small FIFO.
- Presents the queued events on a valid/ready stream for the HPS-side logic, so software no longer busy-reads the PIO.
- Sits between the Qsys interconnect (master side) and local consumer logic.

Parameters:
- DATA_W, 5: number of low readdata bits sampled and compared (1..32).
- POLL_DIV, 1024: clk cycles between poll starts (>= READ_LATENCY+3).
- READ_LATENCY, 1: fixed slave read latency in cycles (1..4); the slave has no waitrequest.
- POLL_ADDR, 0: 2-bit word address driven during a poll.
- DEPTH, 4: event FIFO entries (power of 2, >= 2).
- TS_W, 16: timestamp width.

Ports:
- clk in 1: single clock.
- reset in 1: synchronous, active-high.
- enable in 1: polling enabled; sampled when the poll timer expires.
- clr_ovf in 1: clears the sticky overflow flag.
- avm_address out 2: poll address.
- avm_read out 1: read strobe, one cycle per poll.
- avm_readdata in 32: slave read data.
- evt_valid out 1: event available.
- evt_ready in 1: consumer accepts the head event.
- evt_value out DATA_W: sampled value after the change.
- evt_rise out DATA_W: bits that went 0->1.
- evt_fall out DATA_W: bits that went 1->0.
- evt_ts out TS_W: timestamp counter value at capture.
- overflow out 1: sticky flag; at least one event was dropped.
- primed out 1: a baseline sample exists.

Behaviour:
Everything below happens on the rising edge of clk. Reset wins over every other input.

Reset values:
- avm_read=0, avm_address=POLL_ADDR, evt_valid=0, overflow=0, primed=0.
- FIFO empty, timer=POLL_DIV-1, ts=0, state=IDLE, baseline=0.

ts counter:
- Free-running, increments every cycle, wraps at 2^TS_W-1 -> 0.

Poll timer:
- Counts down every cycle, regardless of enable.
- At 0 it reloads POLL_DIV-1.
- If enable=1 and state=IDLE at that moment, state -> READ.
- If the timer expires in any other state, that poll is skipped (no queuing of poll requests).

FSM: IDLE -> READ -> WAIT -> CAPTURE -> IDLE.
- READ: lasts exactly 1 cycle with avm_read=1 and avm_address=POLL_ADDR. The wait counter loads READ_LATENCY-1.
- WAIT: decrements the counter. When the counter reaches 0, go to CAPTURE. For READ_LATENCY=1, WAIT lasts 1 cycle: readdata is valid in the cycle after READ.
- CAPTURE (1 cycle): s = avm_readdata[DATA_W-1:0]. Bits above DATA_W are ignored.
  - If primed=0: baseline<=s, primed<=1, no event.
  - Otherwise, if s != baseline: push {s, s&~baseline, ~s&baseline, ts}, and baseline<=s.
  - Returns to IDLE.
- Poll-to-event latency: evt_valid rises 2+READ_LATENCY cycles after the READ cycle. With READ_LATENCY=1, that is the cycle after CAPTURE.
- Deasserting enable mid-poll does not abort the poll; the poll completes.

FIFO:
- First-word-fall-through. evt_* reflect the head entry whenever evt_valid=1.
- A pop occurs on evt_valid & evt_ready.
- Push when full: the event is accepted only if a pop happens in the same cycle. Otherwise it is dropped and overflow<=1. The baseline still updates, so the next event is relative to the latest sample.
- Push on empty with evt_ready=1: the entry appears next cycle; there is no combinational bypass.
- The pointers wrap naturally. Full/empty are distinguished by a pointer MSB.
- Overflow and clear in the same cycle: clr_ovf clears overflow in that cycle, except that a drop in that same cycle sets it (set wins).
- evt_ready while empty: ignored.

Decomposition:
- Package pio_poll_pkg holds:
  - the state enum (IDLE, READ, WAIT, CAPTURE);
  - the event struct (value, rise, fall, ts), parameterised through the width constants;
  - the localparam pointer width, clog2(DEPTH).
- Sub-module pio_evt_fifo holds the generic FWFT FIFO with push/pop, full/empty and the overflow-drop rule.
- The top level holds the timer, ts, FSM, baseline and edge-mask logic.

Test Plan (POLL_DIV=8, READ_LATENCY=1, DATA_W=5, DEPTH=4, slave model registered with latency 1):
- Reset released, enable=1, readdata=0x05: first READ pulse when the timer expires; primed=1 after CAPTURE; evt_valid stays 0.
- Baseline 0x05, slave changes to 0x0A, evt_ready=1: one event with value=0x0A, rise=0x0A, fall=0x05; evt_valid is high for exactly 1 cycle, 3 cycles after READ.
- Unchanged readdata across 10 polls: no events; avm_read pulses exactly once every 8 cycles with address 0.
- evt_ready=0, slave toggles 0x00/0x1F on every poll for 6 polls after priming: 4 events stored, then overflow=1. Draining gives values 0x1F, 0x00, 0x1F, 0x00. After clr_ovf, overflow=0.
- readdata upper bits toggling (0xFFFF_FFE0 vs 0x0) with the low 5 bits constant: no event.
- Reset asserted during WAIT, with the FIFO holding 2 entries: next cycle evt_valid=0, avm_read=0, primed=0; the first poll after reset is a priming poll only.
